if_id_skid_reg: RTL and testbench

- Parametrised successor to the IF/ID pipeline register.
- Moves one fetched beat per transfer (instruction, PC, PC+4) from fetch to decode.
- Uses a valid/ready handshake in place of the hold-enable, with a 2-entry skid buffer so in_ready is fully registered.
- Sits between the fetch stage (instruction memory, PC logic) and the decode stage. Hazard-unit flush drops all buffered beats and presents a NOP.

---
 rtl/if_id_skid_reg.sv | 115 +++++++++++
 tb/tb_if_id_skid_reg.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a 2-entry skid
// buffer. The main entry drives out_*, the skid entry absorbs one extra beat,
// so in_ready comes straight from a flop.
// Optional performance counters are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_skid_reg #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013)
`ifdef IF_ID_PERF_CNT_EN
  ,
  parameter int unsigned     CNT_W     = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pcplus4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pcplus4
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic            main_v;
  logic            skid_v;
  logic            in_ready_q;
  logic [ILEN-1:0] main_instr;
  logic [XLEN-1:0] main_pc;
  logic [XLEN-1:0] main_pcplus4;
  logic [ILEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_pcplus4;

  logic accept;
  logic drain;

  assign accept      = in_valid && in_ready_q;
  assign drain       = main_v && out_ready;

  assign in_ready    = in_ready_q;
  assign out_valid   = main_v;
  assign out_instr   = main_instr;
  assign out_pc      = main_pc;
  assign out_pcplus4 = main_pcplus4;

  // Main/skid entry update; flush squashes everything and presents a NOP.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_v       <= 1'b0;
      skid_v       <= 1'b0;
      in_ready_q   <= 1'b1;
      main_instr   <= NOP_INSTR;
      main_pc      <= '0;
      main_pcplus4 <= '0;
      skid_instr   <= NOP_INSTR;
      skid_pc      <= '0;
      skid_pcplus4 <= '0;
    end else if (skid_v) begin
      // in_ready is low here, so the only event is skid refilling main.
      if (drain) begin
        main_instr   <= skid_instr;
        main_pc      <= skid_pc;
        main_pcplus4 <= skid_pcplus4;
        main_v       <= 1'b1;
        skid_v       <= 1'b0;
        in_ready_q   <= 1'b1;
      end
    end else if (!main_v || drain) begin
      if (accept) begin
        main_instr   <= in_instr;
        main_pc      <= in_pc;
        main_pcplus4 <= in_pcplus4;
        main_v       <= 1'b1;
      end else if (main_v) begin
        // Going empty: instruction reverts to NOP, PC fields keep last value.
        main_v       <= 1'b0;
        main_instr   <= NOP_INSTR;
      end
    end else if (accept) begin
      skid_instr   <= in_instr;
      skid_pc      <= in_pc;
      skid_pcplus4 <= in_pcplus4;
      skid_v       <= 1'b1;
      in_ready_q   <= 1'b0;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  // Saturating stall/flush counters; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_v && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: a queue model of the buffered beats
// predicts every output each cycle.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instr, in_pc, in_pcplus4;
  logic [31:0] out_instr, out_pc, out_pcplus4;
`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  stall_cnt4, flush_cnt4;
  logic        d4_in_ready, d4_out_valid;
  logic [31:0] d4_out_instr, d4_out_pc, d4_out_pcplus4;
`endif

  if_id_skid_reg u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_pcplus4(in_pcplus4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pcplus4(out_pcplus4)
`ifdef IF_ID_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

`ifdef IF_ID_PERF_CNT_EN
  if_id_skid_reg #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(d4_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_pcplus4(in_pcplus4),
    .out_valid(d4_out_valid), .out_ready(out_ready),
    .out_instr(d4_out_instr), .out_pc(d4_out_pc), .out_pcplus4(d4_out_pcplus4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
  } beat_t;

  beat_t       mq[$];
  beat_t       last_beat;
  bit          m_rdy;
  int          ntests;
  int          nfail;
  logic [15:0] m_stall, m_flush;
  logic [3:0]  m_stall4, m_flush4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit ordy,
                       input bit fl, input bit r);
    in_valid   = v;
    in_pc      = pc;
    in_instr   = 32'h0A00_0000 + pc;
    in_pcplus4 = pc + 32'd4;
    out_ready  = ordy;
    flush      = fl;
    rst        = r;
  endtask

  // One clock: predict with the model, then check all outputs 1 time unit later.
  task automatic step();
    bit          pre_drn, acc, drn, pre_v;
    logic [31:0] pre_pc;
    beat_t       b;
    pre_drn = (out_valid === 1'b1) && out_ready && !rst && !flush;
    pre_pc  = out_pc;
    pre_v   = (mq.size() > 0);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      last_beat = '0;
      m_rdy     = 1'b1;
      m_stall   = '0; m_flush  = '0;
      m_stall4  = '0; m_flush4 = '0;
    end else begin
      if (pre_v && !out_ready) begin
        if (m_stall  != 16'hFFFF) m_stall  = m_stall  + 16'd1;
        if (m_stall4 != 4'hF)     m_stall4 = m_stall4 + 4'd1;
      end
      if (flush) begin
        if (m_flush  != 16'hFFFF) m_flush  = m_flush  + 16'd1;
        if (m_flush4 != 4'hF)     m_flush4 = m_flush4 + 4'd1;
        mq.delete();
        last_beat = '0;
        m_rdy     = 1'b1;
      end else begin
        acc = in_valid && m_rdy;
        drn = pre_v && out_ready;
        chk("drain_evt", 32'(pre_drn), 32'(drn));
        if (drn) begin
          last_beat = mq.pop_front();
          chk("drain_pc", pre_pc, last_beat.pc);
        end
        if (acc) begin
          b = '{instr: in_instr, pc: in_pc, pcplus4: in_pcplus4};
          mq.push_back(b);
        end
        m_rdy = (mq.size() < 2);
      end
    end
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_instr", out_instr, mq[0].instr);
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_pcplus4", out_pcplus4, mq[0].pcplus4);
    end else begin
      chk("out_instr_nop", out_instr, NOP);
      chk("out_pc_hold", out_pc, last_beat.pc);
      chk("out_pcplus4_hold", out_pcplus4, last_beat.pcplus4);
    end
`ifdef IF_ID_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    chk("stall_cnt4", 32'(stall_cnt4), 32'(m_stall4));
    chk("flush_cnt4", 32'(flush_cnt4), 32'(m_flush4));
`endif
  endtask

  initial begin
    ntests = 0; nfail = 0;
    m_rdy = 1'b1; last_beat = '0;
    m_stall = '0; m_flush = '0; m_stall4 = '0; m_flush4 = '0;
    drive(1'b1, 32'hDEAD_0000, 1'b1, 1'b0, 1'b1);

    // Reset with a beat offered: nothing is captured.
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h13);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();

    // Streaming at one beat per cycle.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 1'b1, 1'b0, 1'b0);
      step();
      chk("stream_pc", out_pc, 32'h100 + 32'(4 * k));
      chk("stream_rdy", 32'(in_ready), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(); step();

    // Stall: 0x200 held in main, 0x204 in skid, 0x208 held upstream.
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h204, 1'b0, 1'b0, 1'b0); step();
    chk("skid_full_rdy", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h208, 1'b0, 1'b0, 1'b0); step();
    chk("stall_hold_pc", out_pc, 32'h200);
    drive(1'b1, 32'h208, 1'b1, 1'b0, 1'b0); step();
    chk("unstall_pc1", out_pc, 32'h204);
    step();
    chk("unstall_pc2", out_pc, 32'h208);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(); step();

    // Flush with skid full and a beat offered in the flush cycle.
    drive(1'b1, 32'h2A0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h2A4, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b0); step();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_instr", out_instr, 32'h13);
    chk("flush_rdy", 32'(in_ready), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(); step();

    // Reset with skid full while decode is stalled.
    drive(1'b1, 32'h380, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h384, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); step();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b0); step();
    chk("post_rst_pc", out_pc, 32'h400);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); step(); step();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * i),
            1'(($urandom % 4) != 0), 1'(($urandom % 20) == 0), 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(); step();

`ifdef IF_ID_PERF_CNT_EN
    // 5 stall cycles and 2 flush cycles after a reset.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1); step();
    drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0); step(); step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); step();
    chk("stall_cnt_5", 32'(stall_cnt), 32'd5);
    chk("flush_cnt_2", 32'(flush_cnt), 32'd2);
    // 20 stall cycles saturate the 4-bit counter.
    drive(1'b1, 32'h600, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("stall_cnt4_sat", 32'(stall_cnt4), 32'd15);
    chk("stall_cnt_25", 32'(stall_cnt), 32'd25);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
